// File: rtl/vm1_bus_responder_if.sv
// CPU-side data-bus bundle of the 1801VM1 soft core: address, write data,
// read/write strobes and byte-write flag towards the slave; read data and
// reply back to the CPU.
interface vm1_bus_responder_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        din;
  logic        dout;
  logic        wtbt;
  logic [15:0] rdata;
  logic        rply;

  modport master (
    output addr, wdata, din, dout, wtbt,
    input  rdata, rply
  );

  modport slave (
    input  addr, wdata, din, dout, wtbt,
    output rdata, rply
  );
endinterface

// File: rtl/vm1_bus_responder.sv
// vm1_bus_responder: CPU-to-controller mailbox on the 1801VM1 data bus.
// Four-word window: CSR, RX FIFO (16 deep, filled locally), TX holding
// register (drained locally) and a scratch word. Programmable wait states,
// interrupt request on IE & RX nonempty.
module vm1_bus_responder #(
  parameter logic [15:0] BASE = 16'o177130,
  parameter int unsigned WAIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  vm1_bus_responder_if.slave bus,
  output logic               irq,
  input  logic               rx_push,
  input  logic [15:0]        rx_data,
  output logic               tx_valid,
  output logic [15:0]        tx_data,
  input  logic               tx_ready
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPLY, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        latch_req, reply_entry;

  logic [2:0]  addr_q;
  logic [15:0] wdata_q;
  logic        wtbt_q;
  logic        read_q;

  logic        strobe, in_window;
  logic        access, rd_access, wr_access;
  logic [1:0]  reg_sel;
  logic        lane_lo, lane_hi;

  logic [15:0] fifo_mem [16];
  logic [3:0]  rd_ptr, wr_ptr;
  logic [4:0]  rx_count;
  logic        fifo_empty, fifo_full;
  logic        pop, push_ok, push_drop;

  logic        rx_ovf, tx_ovr, ie;
  logic        csr_wr, tx_wr, tx_accept, tx_overrun, tx_drain, scr_wr;
  logic [15:0] scratch;
  logic [15:0] csr_value, read_value, rdata_q;

  assign strobe    = bus.din | bus.dout;
  assign in_window = (bus.addr[15:3] == BASE[15:3]);

  // Next-state logic. The IDLE edge only latches the cycle; the WAIT state
  // then spends WAIT+1 ce edges so rply appears WAIT+1 edges after the
  // strobe was sampled, even with WAIT=0.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    latch_req    = 1'b0;
    reply_entry  = 1'b0;
    case (state)
      S_IDLE: begin
        if (strobe && in_window) begin
          latch_req    = 1'b1;
          wait_cnt_nxt = WAIT_CNT;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!strobe) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_nxt   = S_REPLY;
          reply_entry = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      S_REPLY: begin
        if (!strobe) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, advancing only on enabled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else if (ce) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Capture the transfer parameters when a cycle is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 3'd0;
      wdata_q <= 16'd0;
      wtbt_q  <= 1'b0;
      read_q  <= 1'b0;
    end else if (ce && latch_req) begin
      addr_q  <= bus.addr[2:0];
      wdata_q <= bus.wdata;
      wtbt_q  <= bus.wtbt;
      read_q  <= bus.din;
    end
  end

  // Side effects fire once, on the edge that enters REPLY.
  assign access    = ce & reply_entry;
  assign rd_access = access & read_q;
  assign wr_access = access & ~read_q;
  assign reg_sel   = addr_q[2:1];
  assign lane_lo   = ~wtbt_q | ~addr_q[0];
  assign lane_hi   = ~wtbt_q | addr_q[0];

  assign fifo_empty = (rx_count == 5'd0);
  assign fifo_full  = rx_count[4];
  assign pop        = rd_access & (reg_sel == 2'd1) & ~fifo_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = ce & rx_push & (~fifo_full | pop);
  assign push_drop  = ce & rx_push & fifo_full & ~pop;

  // FIFO storage; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    // NOTE: storage array carries no reset; the reset count/pointers make stale contents unreachable.
    if (push_ok) fifo_mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= 4'd0;
      wr_ptr   <= 4'd0;
      rx_count <= 5'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 4'd1;
      if (pop)     rd_ptr <= rd_ptr + 4'd1;
      case ({push_ok, pop})
        2'b10:   rx_count <= rx_count + 5'd1;
        2'b01:   rx_count <= rx_count - 5'd1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  assign csr_wr     = wr_access & (reg_sel == 2'd0);
  assign tx_wr      = wr_access & (reg_sel == 2'd2);
  assign scr_wr     = wr_access & (reg_sel == 2'd3);
  assign tx_drain   = ce & tx_valid & tx_ready;
  assign tx_accept  = tx_wr & (~tx_valid | tx_ready);
  assign tx_overrun = tx_wr & tx_valid & ~tx_ready;

  // CSR flags: sticky error bits (set wins over a same-edge clear) and IE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ovf <= 1'b0;
      tx_ovr <= 1'b0;
      ie     <= 1'b0;
    end else begin
      if (push_drop)                               rx_ovf <= 1'b1;
      else if (csr_wr && lane_hi && wdata_q[15])   rx_ovf <= 1'b0;
      if (tx_overrun)                              tx_ovr <= 1'b1;
      else if (csr_wr && lane_hi && wdata_q[14])   tx_ovr <= 1'b0;
      if (csr_wr && lane_lo)                       ie     <= wdata_q[6];
    end
  end

  // TX holding register: CPU loads it, the local consumer drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 16'd0;
    end else if (tx_accept) begin
      tx_valid <= 1'b1;
      tx_data  <= {lane_hi ? wdata_q[15:8] : 8'd0, lane_lo ? wdata_q[7:0] : 8'd0};
    end else if (tx_drain) begin
      tx_valid <= 1'b0;
    end
  end

  // Scratch word with per-lane writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch <= 16'd0;
    end else if (scr_wr) begin
      if (lane_hi) scratch[15:8] <= wdata_q[15:8];
      if (lane_lo) scratch[7:0]  <= wdata_q[7:0];
    end
  end

  // Read data selection, evaluated on the REPLY entry edge.
  always_comb begin
    csr_value  = {rx_ovf, tx_ovr, 1'b0, rx_count, ~fifo_empty, ie, 5'd0, tx_valid};
    read_value = 16'd0;
    case (reg_sel)
      2'd0:    read_value = csr_value;
      2'd1:    read_value = fifo_empty ? 16'd0 : fifo_mem[rd_ptr];
      2'd2:    read_value = tx_data;
      default: read_value = scratch;
    endcase
  end

  // Read data is captured at REPLY entry and cleared when REPLY ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 16'd0;
    end else if (rd_access) begin
      rdata_q <= read_value;
    end else if (ce && state == S_REPLY && !strobe) begin
      rdata_q <= 16'd0;
    end
  end

  // Registered interrupt request, one enabled edge behind the FIFO state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   irq <= 1'b0;
    else if (ce) irq <= ie & ~fifo_empty;
  end

  assign bus.rdata = rdata_q;
  assign bus.rply  = (state == S_REPLY);

endmodule
